// File: rtl/tinker_rf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package     : tinker_rf_pkg
//  Description : Shared constants for the Tinker register-file access path:
//                register-file command codes, controller FSM encoding and
//                default datapath widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package tinker_rf_pkg;

  // Default datapath geometry: 64-bit registers, 32 entries
  localparam int DEFAULT_DATA_WIDTH = 64;
  localparam int DEFAULT_IDX_WIDTH  = 5;

  // Register-file command codes carried on rf_ctrl
  localparam logic [1:0] RF_CMD_HOLD = 2'b00;
  localparam logic [1:0] RF_CMD_RD1  = 2'b01;
  localparam logic [1:0] RF_CMD_RD2  = 2'b10;
  localparam logic [1:0] RF_CMD_WR   = 2'b11;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_OP_HOLD  = 2'd2
  } rf_state_t;

endpackage : tinker_rf_pkg
`default_nettype wire

// File: rtl/regfile_access_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Interface   : regfile_access_controller_if
//  Description : Bundles the operand-read request stream, the operand return
//                stream, the writeback request and the register-file command
//                bus around the register-file access controller.
//                master : the controller itself
//                slave  : decode/execute stages plus the register file
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_access_controller_if
  import tinker_rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH
);

  // Operand-read request (decode -> controller)
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic                  rd_req_two;
  logic [IDX_WIDTH-1:0]  rd_req_idx_a;
  logic [IDX_WIDTH-1:0]  rd_req_idx_b;

  // Operand return (controller -> execute)
  logic                  op_valid;
  logic                  op_ready;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  // Writeback request (execute -> controller)
  logic                  wb_valid;
  logic                  wb_ready;
  logic [IDX_WIDTH-1:0]  wb_idx;
  logic [DATA_WIDTH-1:0] wb_data;

  // Register-file command bus and output latches
  logic [1:0]            rf_ctrl;
  logic [DATA_WIDTH-1:0] rf_port_1;
  logic [DATA_WIDTH-1:0] rf_port_2;
  logic [DATA_WIDTH-1:0] rf_out_1;
  logic [DATA_WIDTH-1:0] rf_out_2;

  modport master (
    input  rd_req_valid, rd_req_two, rd_req_idx_a, rd_req_idx_b,
    output rd_req_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  wb_valid, wb_idx, wb_data,
    output wb_ready,
    output rf_ctrl, rf_port_1, rf_port_2,
    input  rf_out_1, rf_out_2
  );

  modport slave (
    output rd_req_valid, rd_req_two, rd_req_idx_a, rd_req_idx_b,
    input  rd_req_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output wb_valid, wb_idx, wb_data,
    input  wb_ready,
    input  rf_ctrl, rf_port_1, rf_port_2,
    output rf_out_1, rf_out_2
  );

endinterface : regfile_access_controller_if
`default_nettype wire

// File: rtl/regfile_access_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : regfile_access_controller
//  Description : Initiator side of the 2-bit register-file command bus.
//                Arbitrates writebacks (priority) against operand reads,
//                issues one registered command per cycle and returns the
//                read operands on a valid/ready stream. A read occupies
//                IDLE -> RD_ISSUE -> OP_HOLD; writes may issue from IDLE or
//                while operands are held, never alongside a read command.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_access_controller
  import tinker_rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IDX_WIDTH  = DEFAULT_IDX_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  regfile_access_controller_if.master bus
);

  localparam int PAD_WIDTH = DATA_WIDTH - IDX_WIDTH;

  rf_state_t             state;
  rf_state_t             next_state;

  // Command slot: what the register file samples at the end of this cycle
  logic [1:0]            slot_ctrl;
  logic [DATA_WIDTH-1:0] slot_port_1;
  logic [DATA_WIDTH-1:0] slot_port_2;
  logic [1:0]            slot_ctrl_nxt;
  logic [DATA_WIDTH-1:0] slot_port_1_nxt;
  logic [DATA_WIDTH-1:0] slot_port_2_nxt;

  // Request type of the read in flight; selects whether op_b is meaningful
  logic                  two_req;
  logic                  two_req_nxt;

  logic                  rd_ready;
  logic                  wb_rdy;
  logic                  wb_fire;
  logic                  rd_fire;

  logic                  op_vld;
  logic [DATA_WIDTH-1:0] op_a_val;
  logic [DATA_WIDTH-1:0] op_b_val;

  // State, command slot and request-type registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      slot_ctrl   <= RF_CMD_HOLD;
      slot_port_1 <= '0;
      slot_port_2 <= '0;
      two_req     <= 1'b0;
    end else begin
      state       <= next_state;
      slot_ctrl   <= slot_ctrl_nxt;
      slot_port_1 <= slot_port_1_nxt;
      slot_port_2 <= slot_port_2_nxt;
      two_req     <= two_req_nxt;
    end
  end

  // Arbitration, next state and next command slot; the slot falls back to
  // HOLD so a read command is live for exactly the RD_ISSUE cycle and the
  // output latches stay frozen through OP_HOLD.
  always_comb begin
    next_state      = state;
    slot_ctrl_nxt   = RF_CMD_HOLD;
    slot_port_1_nxt = '0;
    slot_port_2_nxt = '0;
    two_req_nxt     = two_req;
    rd_ready        = 1'b0;
    wb_rdy          = 1'b0;
    wb_fire         = 1'b0;
    rd_fire         = 1'b0;

    case (state)
      ST_IDLE: begin
        wb_rdy   = 1'b1;
        rd_ready = !bus.wb_valid;
        wb_fire  = bus.wb_valid;
        rd_fire  = bus.rd_req_valid && rd_ready;
        if (wb_fire) begin
          slot_ctrl_nxt   = RF_CMD_WR;
          slot_port_1_nxt = bus.wb_data;
          slot_port_2_nxt = {{PAD_WIDTH{1'b0}}, bus.wb_idx};
        end else if (rd_fire) begin
          slot_ctrl_nxt   = bus.rd_req_two ? RF_CMD_RD2 : RF_CMD_RD1;
          slot_port_1_nxt = {{PAD_WIDTH{1'b0}}, bus.rd_req_idx_a};
          slot_port_2_nxt = bus.rd_req_two ? {{PAD_WIDTH{1'b0}}, bus.rd_req_idx_b}
                                           : '0;
          two_req_nxt     = bus.rd_req_two;
          next_state      = ST_RD_ISSUE;
        end
      end

      ST_RD_ISSUE: begin
        next_state = ST_OP_HOLD;
      end

      ST_OP_HOLD: begin
        // Writes leave the latches untouched, so they may drain while the
        // consumer stalls without disturbing the held operands.
        wb_rdy  = 1'b1;
        wb_fire = bus.wb_valid;
        if (wb_fire) begin
          slot_ctrl_nxt   = RF_CMD_WR;
          slot_port_1_nxt = bus.wb_data;
          slot_port_2_nxt = {{PAD_WIDTH{1'b0}}, bus.wb_idx};
        end
        if (bus.op_ready) begin
          next_state = ST_IDLE;
        end
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Operand return; driven straight from the stable register-file latches
  always_comb begin
    op_vld   = 1'b0;
    op_a_val = '0;
    op_b_val = '0;
    if (state == ST_OP_HOLD) begin
      op_vld   = 1'b1;
      op_a_val = bus.rf_out_1;
      op_b_val = two_req ? bus.rf_out_2 : '0;
    end
  end

  assign bus.rd_req_ready = rd_ready;
  assign bus.wb_ready     = wb_rdy;
  assign bus.op_valid     = op_vld;
  assign bus.op_a         = op_a_val;
  assign bus.op_b         = op_b_val;
  assign bus.rf_ctrl      = slot_ctrl;
  assign bus.rf_port_1    = slot_port_1;
  assign bus.rf_port_2    = slot_port_2;

endmodule : regfile_access_controller
`default_nettype wire

// File: tb/tb_regfile_access_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_access_controller
//  Description : Directed bench for regfile_access_controller with a
//                behavioural 32 x 64 register file on the command bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_access_controller;
  import tinker_rf_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_access_controller_if #(.DATA_WIDTH(64), .IDX_WIDTH(5)) bus_if ();

  regfile_access_controller #(.DATA_WIDTH(64), .IDX_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Register file responder: no reset, latches updated by read commands only
  logic [63:0] regs [32] = '{default: 64'h0};
  logic [63:0] lat1 = 64'h0;
  logic [63:0] lat2 = 64'h0;

  // Register file command execution
  always @(posedge clk) begin
    case (bus_if.rf_ctrl)
      RF_CMD_RD1: lat1 <= regs[bus_if.rf_port_1[4:0]];
      RF_CMD_RD2: begin
        lat1 <= regs[bus_if.rf_port_1[4:0]];
        lat2 <= regs[bus_if.rf_port_2[4:0]];
      end
      RF_CMD_WR:  regs[bus_if.rf_port_2[4:0]] <= bus_if.rf_port_1;
      default: ;
    endcase
  end

  assign bus_if.rf_out_1 = lat1;
  assign bus_if.rf_out_2 = lat2;

  // Watchdog against a stuck simulation
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] idx, input logic [63:0] data, input string tag);
    bus_if.wb_valid = 1'b1;
    bus_if.wb_idx   = idx;
    bus_if.wb_data  = data;
    #1;
    chk({tag, ".wb_ready"}, 64'(bus_if.wb_ready), 64'd1);
    tick();
    bus_if.wb_valid = 1'b0;
    chk({tag, ".ctrl"}, 64'(bus_if.rf_ctrl), 64'(RF_CMD_WR));
    chk({tag, ".port1"}, bus_if.rf_port_1, data);
    chk({tag, ".port2"}, bus_if.rf_port_2, 64'(idx));
  endtask

  task automatic do_read(input logic two, input logic [4:0] a, input logic [4:0] b,
                         input logic [63:0] ea, input logic [63:0] eb, input string tag);
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_req_two   = two;
    bus_if.rd_req_idx_a = a;
    bus_if.rd_req_idx_b = b;
    #1;
    chk({tag, ".rd_ready"}, 64'(bus_if.rd_req_ready), 64'd1);
    tick();
    bus_if.rd_req_valid = 1'b0;
    chk({tag, ".ctrl"}, 64'(bus_if.rf_ctrl), two ? 64'(RF_CMD_RD2) : 64'(RF_CMD_RD1));
    chk({tag, ".port1"}, bus_if.rf_port_1, 64'(a));
    chk({tag, ".port2"}, bus_if.rf_port_2, two ? 64'(b) : 64'd0);
    chk({tag, ".early_valid"}, 64'(bus_if.op_valid), 64'd0);
    tick();
    chk({tag, ".op_valid"}, 64'(bus_if.op_valid), 64'd1);
    chk({tag, ".op_a"}, bus_if.op_a, ea);
    chk({tag, ".op_b"}, bus_if.op_b, eb);
    chk({tag, ".ctrl_hold"}, 64'(bus_if.rf_ctrl), 64'(RF_CMD_HOLD));
    bus_if.op_ready = 1'b1;
    tick();
    bus_if.op_ready = 1'b0;
    chk({tag, ".op_done"}, 64'(bus_if.op_valid), 64'd0);
  endtask

  initial begin
    bus_if.rd_req_valid = 1'b0;
    bus_if.rd_req_two   = 1'b0;
    bus_if.rd_req_idx_a = '0;
    bus_if.rd_req_idx_b = '0;
    bus_if.op_ready     = 1'b0;
    bus_if.wb_valid     = 1'b0;
    bus_if.wb_idx       = '0;
    bus_if.wb_data      = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst.op_valid", 64'(bus_if.op_valid), 64'd0);
    chk("rst.ctrl", 64'(bus_if.rf_ctrl), 64'(RF_CMD_HOLD));
    chk("rst.port1", bus_if.rf_port_1, 64'd0);
    chk("rst.port2", bus_if.rf_port_2, 64'd0);
    chk("rst.rd_ready", 64'(bus_if.rd_req_ready), 64'd1);
    chk("rst.wb_ready", 64'(bus_if.wb_ready), 64'd1);

    // Write then two-operand read of the same register
    do_write(5'd5, 64'h1234, "t1.wr");
    do_read(1'b1, 5'd5, 5'd0, 64'h1234, 64'h0, "t1.rd");

    // Simultaneous writeback and read: writeback wins, read follows
    bus_if.wb_valid     = 1'b1;
    bus_if.wb_idx       = 5'd3;
    bus_if.wb_data      = 64'hAA;
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_req_two   = 1'b0;
    bus_if.rd_req_idx_a = 5'd3;
    bus_if.rd_req_idx_b = 5'd0;
    #1;
    chk("t2.rd_ready_blocked", 64'(bus_if.rd_req_ready), 64'd0);
    chk("t2.wb_ready", 64'(bus_if.wb_ready), 64'd1);
    tick();
    bus_if.wb_valid = 1'b0;
    chk("t2.ctrl_wr", 64'(bus_if.rf_ctrl), 64'(RF_CMD_WR));
    chk("t2.port2_wr", bus_if.rf_port_2, 64'd3);
    #1;
    chk("t2.rd_ready", 64'(bus_if.rd_req_ready), 64'd1);
    tick();
    bus_if.rd_req_valid = 1'b0;
    chk("t2.ctrl_rd1", 64'(bus_if.rf_ctrl), 64'(RF_CMD_RD1));
    chk("t2.port1_rd", bus_if.rf_port_1, 64'd3);
    tick();
    chk("t2.op_valid", 64'(bus_if.op_valid), 64'd1);
    chk("t2.op_a", bus_if.op_a, 64'hAA);
    bus_if.op_ready = 1'b1;
    tick();
    bus_if.op_ready = 1'b0;

    // Two-operand read leaves latch 2 non-zero; single read must zero op_b
    do_write(5'd7, 64'h77, "t3.wr");
    do_read(1'b1, 5'd5, 5'd3, 64'h1234, 64'hAA, "t3.rd2");
    do_read(1'b0, 5'd7, 5'd0, 64'h77, 64'h0, "t3.rd1");

    // Consumer stalls in OP_HOLD while writes to idx 7 drain
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_req_two   = 1'b1;
    bus_if.rd_req_idx_a = 5'd7;
    bus_if.rd_req_idx_b = 5'd5;
    tick();
    bus_if.rd_req_valid = 1'b0;
    tick();
    chk("t4.op_a0", bus_if.op_a, 64'h77);
    chk("t4.op_b0", bus_if.op_b, 64'h1234);
    for (int k = 0; k < 5; k++) begin
      bus_if.wb_valid     = 1'b1;
      bus_if.wb_idx       = 5'd7;
      bus_if.wb_data      = 64'h55;
      bus_if.rd_req_valid = 1'b1;
      #1;
      chk("t4.wb_ready", 64'(bus_if.wb_ready), 64'd1);
      chk("t4.rd_ready", 64'(bus_if.rd_req_ready), 64'd0);
      tick();
      chk("t4.ctrl_wr", 64'(bus_if.rf_ctrl), 64'(RF_CMD_WR));
      chk("t4.op_valid", 64'(bus_if.op_valid), 64'd1);
      chk("t4.op_a", bus_if.op_a, 64'h77);
      chk("t4.op_b", bus_if.op_b, 64'h1234);
    end
    bus_if.wb_valid     = 1'b0;
    bus_if.rd_req_valid = 1'b0;
    bus_if.op_ready     = 1'b1;
    tick();
    bus_if.op_ready = 1'b0;
    do_read(1'b0, 5'd7, 5'd0, 64'h55, 64'h0, "t4.rd");

    // Back-to-back writes, then read each back
    for (int i = 1; i <= 4; i++) begin
      do_write(5'(i), 64'(i * 16), "t5.wr");
    end
    for (int i = 1; i <= 4; i++) begin
      do_read(1'b0, 5'(i), 5'd0, 64'(i * 16), 64'h0, "t5.rd");
    end

    // Last write to the same index wins
    do_write(5'd9, 64'h111, "t5b.wr1");
    do_write(5'd9, 64'h222, "t5b.wr2");
    do_read(1'b0, 5'd9, 5'd0, 64'h222, 64'h0, "t5b.rd");

    // Reset during RD_ISSUE abandons the read
    bus_if.rd_req_valid = 1'b1;
    bus_if.rd_req_two   = 1'b1;
    bus_if.rd_req_idx_a = 5'd1;
    bus_if.rd_req_idx_b = 5'd2;
    tick();
    bus_if.rd_req_valid = 1'b0;
    chk("t6.ctrl_rd2", 64'(bus_if.rf_ctrl), 64'(RF_CMD_RD2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6.op_valid", 64'(bus_if.op_valid), 64'd0);
    chk("t6.ctrl", 64'(bus_if.rf_ctrl), 64'(RF_CMD_HOLD));
    chk("t6.port1", bus_if.rf_port_1, 64'd0);
    chk("t6.port2", bus_if.rf_port_2, 64'd0);
    chk("t6.rd_ready", 64'(bus_if.rd_req_ready), 64'd1);
    tick();
    chk("t6.op_valid_late", 64'(bus_if.op_valid), 64'd0);
    do_read(1'b0, 5'd4, 5'd0, 64'h40, 64'h0, "t6.rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_access_controller
`default_nettype wire
